// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 audio path.
// Holds the DAC mixer defaults and its control state encoding.
package opl3_pkg;

  localparam int DAC_MIX_NUM_SRC    = 4;
  localparam int DAC_MIX_VOL_WIDTH  = 8;
  localparam int DAC_MIX_UNITY_VOL  = 1 << (DAC_MIX_VOL_WIDTH - 1);

  typedef enum logic [1:0] {
    DM_IDLE   = 2'd0,
    DM_ACCUM  = 2'd1,
    DM_MASTER = 2'd2,
    DM_OUTPUT = 2'd3
  } dac_mixer_state_t;

endpackage

// File: rtl/dac_mixer_sat_shift.sv
// Signed arithmetic right shift, then left shift, then saturation to OUT_W bits.
// clip is high whenever the value had to be clamped.
module sat_shift #(
  parameter int IN_W   = 40,
  parameter int OUT_W  = 16,
  parameter int RSHIFT = 7,
  parameter int LSHIFT = 0
) (
  input  logic signed [IN_W-1:0]  value,
  output logic signed [OUT_W-1:0] result,
  output logic                    clip
);

  // Wide enough that the left shift can never lose the sign.
  localparam int EXT_W = IN_W + LSHIFT + OUT_W;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0]  shr;
  logic signed [EXT_W-1:0] ext;

  assign shr = value >>> RSHIFT;
  assign ext = EXT_W'(shr) <<< LSHIFT;

  always_comb begin
    result = ext[OUT_W-1:0];
    clip   = 1'b0;
    if (ext > MAX_V) begin
      result = MAX_V[OUT_W-1:0];
      clip   = 1'b1;
    end else if (ext < MIN_V) begin
      result = MIN_V[OUT_W-1:0];
      clip   = 1'b1;
    end
  end

endmodule

// File: rtl/dac_mixer.sv
// Multi-source stereo mixer: one serial MAC per side over NUM_SRC sources,
// then master volume, width adaptation and saturation to the DAC width.
module dac_mixer
  import opl3_pkg::*;
#(
  parameter int NUM_SRC   = DAC_MIX_NUM_SRC,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int VOL_WIDTH = DAC_MIX_VOL_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_tick,
  input  logic [NUM_SRC*IN_WIDTH-1:0]    src_l,
  input  logic [NUM_SRC*IN_WIDTH-1:0]    src_r,
  input  logic [NUM_SRC*VOL_WIDTH-1:0]   src_vol,
  input  logic [NUM_SRC-1:0]             src_mute,
  input  logic [VOL_WIDTH-1:0]           master_vol,
  output logic                           busy,
  output logic                           sample_valid,
  output logic signed [OUT_WIDTH-1:0]    sample_l,
  output logic signed [OUT_WIDTH-1:0]    sample_r,
  output logic                           clip_l,
  output logic                           clip_r,
  output logic                           overrun
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TERM_W = IN_WIDTH + VOL_WIDTH + 1;
  localparam int ACC_W  = TERM_W + $clog2(NUM_SRC);
  localparam int PROD_W = ACC_W + VOL_WIDTH + 1;
  localparam int NORM   = VOL_WIDTH - 1;

  dac_mixer_state_t state_reg, state_next;

  logic [IDX_W-1:0]             k_reg;
  logic [NUM_SRC*IN_WIDTH-1:0]  snap_l_reg, snap_r_reg;
  logic [NUM_SRC*VOL_WIDTH-1:0] snap_vol_reg;
  logic [NUM_SRC-1:0]           snap_mute_reg;
  logic [VOL_WIDTH-1:0]         snap_master_reg;
  logic signed [ACC_W-1:0]      acc_l_reg, acc_r_reg;
  logic signed [OUT_WIDTH-1:0]  sample_l_reg, sample_r_reg;
  logic                         clip_l_reg, clip_r_reg, overrun_reg;

  logic snap_en, acc_en, out_en, last_src;

  // Per-source views of the snapshot; a muted source simply has zero gain.
  logic signed [IN_WIDTH-1:0] lane_l   [NUM_SRC];
  logic signed [IN_WIDTH-1:0] lane_r   [NUM_SRC];
  logic [VOL_WIDTH-1:0]       lane_vol [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
      assign lane_l[gi]   = snap_l_reg[gi*IN_WIDTH +: IN_WIDTH];
      assign lane_r[gi]   = snap_r_reg[gi*IN_WIDTH +: IN_WIDTH];
      assign lane_vol[gi] = snap_mute_reg[gi] ? '0 : snap_vol_reg[gi*VOL_WIDTH +: VOL_WIDTH];
    end
  endgenerate

  logic signed [VOL_WIDTH:0] gain_s, mvol_s;
  logic signed [TERM_W-1:0]  term_l, term_r;
  logic signed [ACC_W-1:0]   acc_shr_l, acc_shr_r;
  logic signed [PROD_W-1:0]  prod_l, prod_r;
  logic signed [OUT_WIDTH-1:0] sat_l, sat_r;
  logic                      sat_clip_l, sat_clip_r;

  assign gain_s    = {1'b0, lane_vol[k_reg]};
  assign term_l    = TERM_W'(lane_l[k_reg]) * TERM_W'(gain_s);
  assign term_r    = TERM_W'(lane_r[k_reg]) * TERM_W'(gain_s);
  assign last_src  = (k_reg == IDX_W'(NUM_SRC - 1));

  assign mvol_s    = {1'b0, snap_master_reg};
  assign acc_shr_l = acc_l_reg >>> NORM;
  assign acc_shr_r = acc_r_reg >>> NORM;
  assign prod_l    = PROD_W'(acc_shr_l) * PROD_W'(mvol_s);
  assign prod_r    = PROD_W'(acc_shr_r) * PROD_W'(mvol_s);

  // Master renormalisation and output width adaptation share one stage.
  sat_shift #(
    .IN_W  (PROD_W),
    .OUT_W (OUT_WIDTH),
    .RSHIFT(NORM),
    .LSHIFT(OUT_WIDTH - IN_WIDTH)
  ) u_sat_l (
    .value (prod_l),
    .result(sat_l),
    .clip  (sat_clip_l)
  );

  sat_shift #(
    .IN_W  (PROD_W),
    .OUT_W (OUT_WIDTH),
    .RSHIFT(NORM),
    .LSHIFT(OUT_WIDTH - IN_WIDTH)
  ) u_sat_r (
    .value (prod_r),
    .result(sat_r),
    .clip  (sat_clip_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= DM_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    snap_en    = 1'b0;
    acc_en     = 1'b0;
    out_en     = 1'b0;
    case (state_reg)
      DM_IDLE: begin
        if (sample_tick) begin
          snap_en    = 1'b1;
          state_next = DM_ACCUM;
        end
      end
      DM_ACCUM: begin
        acc_en = 1'b1;
        if (last_src) state_next = DM_MASTER;
      end
      DM_MASTER: begin
        out_en     = 1'b1;
        state_next = DM_OUTPUT;
      end
      DM_OUTPUT: state_next = DM_IDLE;
      default:   state_next = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_reg           <= '0;
      snap_l_reg      <= '0;
      snap_r_reg      <= '0;
      snap_vol_reg    <= '0;
      snap_mute_reg   <= '0;
      snap_master_reg <= '0;
      acc_l_reg       <= '0;
      acc_r_reg       <= '0;
      sample_l_reg    <= '0;
      sample_r_reg    <= '0;
      clip_l_reg      <= 1'b0;
      clip_r_reg      <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      overrun_reg <= sample_tick && (state_reg != DM_IDLE);
      if (snap_en) begin
        snap_l_reg      <= src_l;
        snap_r_reg      <= src_r;
        snap_vol_reg    <= src_vol;
        snap_mute_reg   <= src_mute;
        snap_master_reg <= master_vol;
        acc_l_reg       <= '0;
        acc_r_reg       <= '0;
        k_reg           <= '0;
      end
      if (acc_en) begin
        acc_l_reg <= acc_l_reg + ACC_W'(term_l);
        acc_r_reg <= acc_r_reg + ACC_W'(term_r);
        if (!last_src) k_reg <= k_reg + 1'b1;
      end
      if (out_en) begin
        sample_l_reg <= sat_l;
        sample_r_reg <= sat_r;
        clip_l_reg   <= sat_clip_l;
        clip_r_reg   <= sat_clip_r;
      end
    end
  end

  assign busy         = (state_reg != DM_IDLE);
  assign sample_valid = (state_reg == DM_OUTPUT);
  assign sample_l     = sample_l_reg;
  assign sample_r     = sample_r_reg;
  assign clip_l       = clip_l_reg;
  assign clip_r       = clip_r_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_dac_mixer.sv
// Scoreboard bench for dac_mixer: a driver pushes expected samples and overrun
// cycles into queues, a negedge monitor pops and compares as the DUT reports them.
module tb_dac_mixer;

  localparam int NS  = 4;
  localparam int IW  = 16;
  localparam int OW  = 16;
  localparam int VW  = 8;
  localparam int LAT = NS + 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 sample_tick = 1'b0;
  logic [NS*IW-1:0]     src_l = '0;
  logic [NS*IW-1:0]     src_r = '0;
  logic [NS*VW-1:0]     src_vol = '0;
  logic [NS-1:0]        src_mute = '0;
  logic [VW-1:0]        master_vol = '0;
  logic                 busy, sample_valid, clip_l, clip_r, overrun;
  logic signed [OW-1:0] sample_l, sample_r;

  dac_mixer #(
    .NUM_SRC  (NS),
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .VOL_WIDTH(VW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .src_l       (src_l),
    .src_r       (src_r),
    .src_vol     (src_vol),
    .src_mute    (src_mute),
    .master_vol  (master_vol),
    .busy        (busy),
    .sample_valid(sample_valid),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .clip_l      (clip_l),
    .clip_r      (clip_r),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint l;
    longint r;
    bit     cl;
    bit     cr;
    int     at;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  exp_t mon_e;
  int   mon_c;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic longint sat(input longint y, output bit c);
    longint hi = (longint'(1) << (OW - 1)) - 1;
    longint lo = -(longint'(1) << (OW - 1));
    c = 1'b0;
    if (y > hi) begin c = 1'b1; return hi; end
    if (y < lo) begin c = 1'b1; return lo; end
    return y;
  endfunction

  // Reference: integer mix of the current inputs with floor-divisions by unity gain.
  function automatic exp_t model();
    exp_t   e;
    longint acc_l = 0, acc_r = 0, unity = longint'(1) << (VW - 1);
    for (int i = 0; i < NS; i++) begin
      int sl = $signed(src_l[i*IW +: IW]);
      int sr = $signed(src_r[i*IW +: IW]);
      int v  = int'(src_vol[i*VW +: VW]);
      if (!src_mute[i]) begin
        acc_l += longint'(sl) * longint'(v);
        acc_r += longint'(sr) * longint'(v);
      end
    end
    e.l = sat(fdiv(fdiv(acc_l, unity) * longint'(master_vol), unity) * (longint'(1) << (OW - IW)), e.cl);
    e.r = sat(fdiv(fdiv(acc_r, unity) * longint'(master_vol), unity) * (longint'(1) << (OW - IW)), e.cr);
    e.at = 0;
    return e;
  endfunction

  function automatic exp_t mk(input longint l, input longint r, input bit cl, input bit cr);
    exp_t e;
    e.l = l; e.r = r; e.cl = cl; e.cr = cr; e.at = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: got l=%0d r=%0d at cycle %0d, expected no sample", sample_l, sample_r, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          $display("sample cycle=%0d l=%0d r=%0d clip=%b%b (want cycle=%0d l=%0d r=%0d clip=%b%b)",
                   cyc, sample_l, sample_r, clip_l, clip_r, mon_e.at, mon_e.l, mon_e.r, mon_e.cl, mon_e.cr);
          chk("valid_cycle", cyc, mon_e.at);
          chk("sample_l", sample_l, mon_e.l);
          chk("sample_r", sample_r, mon_e.r);
          chk("clip_l", clip_l, mon_e.cl);
          chk("clip_r", clip_r, mon_e.cr);
        end
      end
      if (overrun) begin
        if (ovr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_overrun: got pulse at cycle %0d, expected none", cyc);
        end else begin
          mon_c = ovr_q.pop_front();
          $display("overrun cycle=%0d (want %0d)", cyc, mon_c);
          chk("overrun_cycle", cyc, mon_c);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input int l, input int r, input int v);
    src_l[i*IW +: IW]   = IW'(l);
    src_r[i*IW +: IW]   = IW'(r);
    src_vol[i*VW +: VW] = VW'(v);
  endtask

  task automatic clear_src();
    src_l = '0; src_r = '0; src_vol = '0; src_mute = '0;
  endtask

  task automatic rand_inputs();
    src_l      = {$urandom(), $urandom()};
    src_r      = {$urandom(), $urandom()};
    src_vol    = $urandom();
    src_mute   = ($urandom_range(0, 3) == 0) ? NS'($urandom()) : '0;
    master_vol = ($urandom_range(0, 1) == 0) ? VW'(128) : VW'($urandom());
  endtask

  // Issue a tick now (DUT idle) and expect its sample LAT cycles later.
  task automatic tick_push(input exp_t e);
    e.at = cyc + LAT;
    exp_q.push_back(e);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic wait_mix();
    repeat (LAT) step();
  endtask

  initial begin
    int extra;

    // Reset held with random activity on the inputs.
    repeat (8) begin
      rand_inputs();
      sample_tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_sample", {sample_l, sample_r}, 0);
      chk("rst_clip", {clip_l, clip_r}, 0);
      @(posedge clk);
      #1;
    end
    sample_tick = 1'b0;
    reset_n = 1'b1;
    step();

    // Unity passthrough.
    clear_src();
    master_vol = 8'd128;
    set_src(0, 1000, -1000, 128);
    tick_push(mk(1000, -1000, 0, 0));
    chk("busy_after_tick", busy, 1);
    wait_mix();
    chk("idle_after_mix", busy, 0);

    // Gain and floor behaviour.
    set_src(0, 1001, -1001, 64);
    tick_push(mk(500, -501, 0, 0));
    wait_mix();
    set_src(0, 4, 4, 128);
    master_vol = 8'd64;
    tick_push(mk(2, 2, 0, 0));
    wait_mix();

    // Saturation, then muting.
    master_vol = 8'd128;
    for (int i = 0; i < NS; i++) set_src(i, 30000, -30000, 128);
    tick_push(mk(32767, -32768, 1, 1));
    wait_mix();
    src_mute = 4'b1110;
    tick_push(mk(30000, -30000, 0, 0));
    wait_mix();

    // Snapshot and overrun: inputs change after the tick, second tick while busy.
    clear_src();
    set_src(0, 1000, -1000, 128);
    tick_push(mk(1000, -1000, 0, 0));
    set_src(0, 0, 0, 0);
    step();
    step();
    sample_tick = 1'b1;
    ovr_q.push_back(cyc + 1);
    step();
    sample_tick = 1'b0;
    repeat (3) step();

    // Reset mid-mix abandons the sample and clears outputs.
    set_src(0, 777, -333, 128);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_sample_l", sample_l, 0);
    chk("midrst_sample_r", sample_r, 0);
    chk("midrst_busy", busy, 0);
    repeat (8) step();
    tick_push(mk(777, -333, 0, 0));
    wait_mix();

    // Randomised mixes with input churn, stray ticks and back-to-back starts.
    repeat (40) begin
      rand_inputs();
      tick_push(model());
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, LAT) : 0;
      for (int j = 1; j <= LAT; j++) begin
        rand_inputs();
        if (j == extra) begin
          sample_tick = 1'b1;
          ovr_q.push_back(cyc + 1);
        end
        step();
        sample_tick = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
    end

    for (int n = 0; n < 50 && (exp_q.size() != 0 || ovr_q.size() != 0); n++) step();
    chk("pending_samples", exp_q.size(), 0);
    chk("pending_overruns", ovr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
